fetch_prefetch_stage: RTL and testbench
=======================================

// Module: fetch_prefetch_stage
// PURPOSE
//  Parametrised fetch stage with a prefetch queue: drives a PC that issues requests to an
//  instruction memory over a valid/ready handshake (variable, in-order response latency) and
//  buffers returned instructions in a FIFO_DEPTH-entry queue feeding decode. A decode redirect
//  (branch or jump) flushes the queue and discards every in-flight response.
// PARAMETERS
//  ADDRESS_WIDTH  32  PC / memory address width, in bits
//  INSTR_WIDTH    32  instruction width, in bits
//  FIFO_DEPTH     4   prefetch queue entries; power of 2, >=2; also the max in-flight requests
//  RESET_PC       0   PC loaded at reset
// PORTS
//  i_CLK            in   1   clock; the block's only clock
//  i_RST            in   1   reset; synchronous, active-low
//  i_RedirectD      in   1   decode redirect (PCSrcD | JumpD)
//  i_PCNextD        in   AW  redirect target
//  i_StallD         in   1   decode not accepting this cycle
//  o_ImemReqValid   out  1   memory request valid
//  o_ImemAddr       out  AW  memory request address (= fetch PC)
//  i_ImemReqReady   in   1   memory accepts request
//  i_ImemRspValid   in   1   response valid (in order, one per accepted request)
//  i_ImemRspInstr   in   IW  response instruction
//  o_ValidF         out  1   queue head valid
//  o_InstrF         out  IW  queue head instruction
//  o_PCPlus4F       out  AW  queue head PC+4
// BEHAVIOUR
//  - Reset (i_RST=0 at posedge): fetch PC=RESET_PC, rsp PC=RESET_PC, queue empty, inflight=0,
//    drop=0; o_ValidF=0, o_ImemReqValid=0 during the reset cycle; o_InstrF/o_PCPlus4F=0 when empty.
//  - Counters: inflight = accepted requests without a response (stale ones included);
//    drop = stale responses still to be discarded (drop <= inflight); count = queue occupancy.
//  - Issue: o_ImemReqValid = !i_RedirectD && (inflight + count < FIFO_DEPTH); o_ImemAddr = fetch PC.
//    req_fire = valid & ready -> fetch PC += 4 (mod 2^AW, wraps silently), inflight += 1.
//  - Response: rsp_fire = i_ImemRspValid. If drop>0 or i_RedirectD: discard, drop -= 1 when drop>0.
//    Else push {rsp PC+4, instr}; rsp PC += 4. inflight -= 1 either way.
//    Push occurs without overflow by construction; a push while full is a design error.
//  - Pop: o_ValidF & !i_StallD removes the head; push+pop same cycle leaves count unchanged.
//  - Pushed entry is visible on o_ValidF the cycle after rsp_fire (1 cycle registered).
//    Minimum reset-to-first-valid = memory latency + 1 cycle.
//  - Redirect (i_RedirectD=1) wins over stall, pop, push: queue flushed (count=0) next cycle;
//    fetch PC and rsp PC <= i_PCNextD; drop <= inflight_next (all in-flight become stale,
//    counting any rsp_fire in the same cycle as already consumed); no request issued that cycle.
//  - Back-to-back redirects: each recomputes drop from current inflight; last target wins.
//  - i_RedirectD is ignored during reset. Reset mid-operation discards queue and in-flight
//    bookkeeping; memory shall be reset by the same i_RST, so no stale responses follow reset.
//  - inflight, drop and count are each $clog2(FIFO_DEPTH)+1 bits wide.
// TESTING
//  1. Zero-wait memory (ready=1, rsp 1 cycle after accept), StallD=0: PCs 0,4,8.. stream,
//     o_ValidF first asserts 2 cycles after reset release, o_PCPlus4F = 4,8,12...
//  2. StallD=1 held 10 cycles, DEPTH=4: exactly 4 requests issued, then ReqValid=0; queue holds
//     PC 0..12 unchanged; release -> drains in order with no loss or duplication.
//  3. Memory latency 3, redirect to 0x100 with 2 in flight: both responses discarded,
//     next o_InstrF is from 0x100 with o_PCPlus4F=0x104.
//  4. Redirect in the same cycle as rsp_fire and StallD=1: response dropped, queue empty next
//     cycle, drop = remaining in-flight count, fetch restarts at target.
//  5. ReqReady toggling randomly, 1000 cycles, random redirects: scoreboard shows decode receives
//     exactly the sequential instruction stream from each redirect target, in order.
//  6. Reset asserted mid-stream with 3 in flight: next cycle o_ValidF=0, inflight=0,
//     first request after release at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_stage.sv
// Fetch stage with a prefetch queue. Issues PC-sequential requests to the
// instruction memory, buffers in-order responses in a small ring buffer and
// hands them to decode. A decode redirect flushes the queue and marks every
// outstanding request as stale so its response is thrown away.
module fetch_prefetch_stage #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned INSTR_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_RedirectD,
    input  logic [ADDRESS_WIDTH-1:0] i_PCNextD,
    input  logic                     i_StallD,
    output logic                     o_ImemReqValid,
    output logic [ADDRESS_WIDTH-1:0] o_ImemAddr,
    input  logic                     i_ImemReqReady,
    input  logic                     i_ImemRspValid,
    input  logic [INSTR_WIDTH-1:0]   i_ImemRspInstr,
    output logic                     o_ValidF,
    output logic [INSTR_WIDTH-1:0]   o_InstrF,
    output logic [ADDRESS_WIDTH-1:0] o_PCPlus4F
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] FOUR = ADDRESS_WIDTH'(4);

    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic [ADDRESS_WIDTH-1:0] rsp_pc;
    logic [CW-1:0]            inflight;
    logic [CW-1:0]            drop;
    logic [CW-1:0]            count;
    logic [PW-1:0]            rd_ptr;
    logic [PW-1:0]            wr_ptr;

    logic [INSTR_WIDTH-1:0]   instr_mem [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] pcp4_mem  [FIFO_DEPTH];

    logic          req_fire;
    logic          rsp_fire;
    logic          discard;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic [CW:0]   occupancy;
    logic [CW-1:0] inflight_next;

    // Requests are throttled so that in-flight plus buffered never exceeds the
    // queue size; this is what guarantees a free slot for every response.
    assign occupancy      = {1'b0, inflight} + {1'b0, count};
    assign o_ImemReqValid = i_RST && !i_RedirectD && (occupancy < DEPTH_C);
    assign o_ImemAddr     = fetch_pc;

    assign req_fire      = o_ImemReqValid && i_ImemReqReady;
    assign rsp_fire      = i_ImemRspValid;
    assign discard       = (drop != '0) || i_RedirectD;
    assign push          = rsp_fire && !discard;
    assign inflight_next = inflight + CW'(req_fire) - CW'(rsp_fire);

    assign head_valid = i_RST && (count != '0);
    assign pop        = head_valid && !i_StallD && !i_RedirectD;

    assign o_ValidF   = head_valid;
    assign o_InstrF   = head_valid ? instr_mem[rd_ptr] : '0;
    assign o_PCPlus4F = head_valid ? pcp4_mem[rd_ptr]  : '0;

    // Control state: PCs, outstanding/stale counters and queue pointers.
    // A redirect overrides every other update in the same cycle.
    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= inflight_next;
            if (i_RedirectD) begin
                fetch_pc <= i_PCNextD;
                rsp_pc   <= i_PCNextD;
                drop     <= inflight_next;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + FOUR;
                if (push) begin
                    rsp_pc <= rsp_pc + FOUR;
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (rsp_fire && drop != '0)
                    drop <= drop - CW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Queue storage; contents need no reset since count gates visibility.
    always_ff @(posedge i_CLK) begin
        if (i_RST && push) begin
            instr_mem[wr_ptr] <= i_ImemRspInstr;
            pcp4_mem[wr_ptr]  <= rsp_pc + FOUR;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Bench for fetch_prefetch_stage: a queue-based memory model with variable
// in-order latency, plus a reference of the expected decode stream (sequential
// from the last redirect target) and the expected request address stream.
module tb_fetch_prefetch_stage;

    localparam int unsigned D = 4;
    localparam logic [31:0] RPC = 32'h0;

    logic        clk = 1'b0;
    logic        i_RST, i_RedirectD, i_StallD, i_ImemReqReady, i_ImemRspValid;
    logic [31:0] i_PCNextD, i_ImemRspInstr;
    logic        o_ImemReqValid, o_ValidF;
    logic [31:0] o_ImemAddr, o_InstrF, o_PCPlus4F;

    always #5 clk = ~clk;

    fetch_prefetch_stage #(
        .ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .FIFO_DEPTH(D), .RESET_PC(RPC)
    ) dut (
        .i_CLK(clk), .i_RST(i_RST), .i_RedirectD(i_RedirectD), .i_PCNextD(i_PCNextD),
        .i_StallD(i_StallD), .o_ImemReqValid(o_ImemReqValid), .o_ImemAddr(o_ImemAddr),
        .i_ImemReqReady(i_ImemReqReady), .i_ImemRspValid(i_ImemRspValid),
        .i_ImemRspInstr(i_ImemRspInstr), .o_ValidF(o_ValidF), .o_InstrF(o_InstrF),
        .o_PCPlus4F(o_PCPlus4F)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       memq[$];
    int          n_chk = 0, n_fail = 0, cyc = 0, n_pop = 0;
    int          lat_min = 1, lat_max = 1;
    bit          rst_n, redir, stall, rdy;
    logic [31:0] tgt;
    logic [31:0] exp_pc, exp_fetch;
    bit          s_valid, s_reqv, s_fire;
    logic [31:0] s_pcp4, s_instr, s_addr;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_96E1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs and memory response at negedge, check the
    // popped head and issued address against the reference, record accepts.
    task automatic step();
        logic [31:0] e_instr, e_pcp4;
        int lat;
        @(negedge clk);
        i_RST = rst_n; i_RedirectD = redir; i_PCNextD = tgt;
        i_StallD = stall; i_ImemReqReady = rdy;
        i_ImemRspValid = 1'b0; i_ImemRspInstr = $urandom;
        if (rst_n && memq.size() > 0 && memq[0].due <= cyc) begin
            i_ImemRspValid = 1'b1;
            i_ImemRspInstr = imem(memq[0].addr);
            memq.delete(0);
        end
        #1;
        s_valid = o_ValidF; s_reqv = o_ImemReqValid; s_pcp4 = o_PCPlus4F;
        s_instr = o_InstrF; s_addr = o_ImemAddr;
        s_fire  = o_ImemReqValid && rdy;
        if (!rst_n) begin
            chk("rst_validf", o_ValidF, 0);
            chk("rst_reqvalid", o_ImemReqValid, 0);
            memq.delete();
            exp_pc = RPC; exp_fetch = RPC; s_fire = 1'b0;
        end else begin
            if (o_ValidF && !stall && !redir) begin
                e_instr = imem(exp_pc);
                e_pcp4  = exp_pc + 32'd4;
                chk("pop_instr", o_InstrF, e_instr);
                chk("pop_pcp4", o_PCPlus4F, e_pcp4);
                exp_pc = e_pcp4;
                n_pop++;
            end
            if (!o_ValidF) chk("empty_zero", {o_InstrF, o_PCPlus4F}, 0);
            if (s_fire) begin
                chk("req_addr", o_ImemAddr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
            if (redir) begin
                chk("redir_noreq", o_ImemReqValid, 0);
                exp_pc = tgt; exp_fetch = tgt;
            end
        end
        @(posedge clk);
        cyc++;
        if (s_fire) begin
            lat = int'($urandom_range(lat_max, lat_min));
            memq.push_back('{s_addr, cyc + lat - 1});
            chk("max_inflight", memq.size() <= D, 1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redir = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        bit got, done;
        int nf;
        i_RST = 1'b0; i_RedirectD = 1'b0; i_PCNextD = '0; i_StallD = 1'b0;
        i_ImemReqReady = 1'b0; i_ImemRspValid = 1'b0; i_ImemRspInstr = '0;
        redir = 0; stall = 0; rdy = 1; tgt = '0;
        exp_pc = RPC; exp_fetch = RPC;
        rst_n = 1'b0;
        step();
        do_reset();

        // 1: zero-wait memory streams; first valid two cycles after release
        lat_min = 1; lat_max = 1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k < 2) chk("t1_no_early_valid", s_valid, 0);
            if (k == 2) begin
                chk("t1_first_valid", s_valid, 1);
                chk("t1_first_pcp4", s_pcp4, 32'h4);
            end
        end

        // 2: decode stalled -> exactly DEPTH requests, queue held, then drains
        do_reset();
        stall = 1; nf = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            nf += int'(s_fire);
        end
        #1;
        chk("t2_req_count", nf, D);
        chk("t2_reqvalid_off", s_reqv, 0);
        chk("t2_head_held", s_pcp4, 32'h4);
        chk("t2_full", dut.count, D);
        stall = 0;
        for (int k = 0; k < 12; k++) step();
        chk("t2_drained", exp_pc >= 32'h10, 1);

        // 3: latency 3, redirect with two requests in flight
        do_reset();
        lat_min = 3; lat_max = 3;
        step(); step();
        #1;
        chk("t3_inflight", dut.inflight, 2);
        redir = 1; tgt = 32'h100;
        step();
        redir = 0;
        #1;
        chk("t3_drop", dut.drop, 2);
        got = 0;
        for (int k = 0; k < 30; k++) begin
            if (!got) begin
                step();
                if (s_valid) begin
                    got = 1;
                    chk("t3_first_pcp4", s_pcp4, 32'h104);
                    chk("t3_first_instr", s_instr, imem(32'h100));
                end
            end
        end
        chk("t3_got_valid", got, 1);

        // 4: redirect coincident with a response while stalled
        do_reset();
        lat_min = 2; lat_max = 2; stall = 1; done = 0;
        for (int k = 0; k < 10; k++) begin
            if (!done) begin
                if (memq.size() > 0 && memq[0].due <= cyc) begin
                    redir = 1; tgt = 32'h200;
                    step();
                    redir = 0; done = 1;
                    #1;
                    chk("t4_drop", dut.drop, memq.size());
                    chk("t4_inflight", dut.inflight, memq.size());
                end else begin
                    step();
                end
            end
        end
        chk("t4_coincided", done, 1);
        step();
        chk("t4_flushed", s_valid, 0);
        chk("t4_restart_fire", s_fire, 1);
        chk("t4_restart_addr", s_addr, 32'h200);
        stall = 0;
        for (int k = 0; k < 15; k++) step();

        // 5: random ready, stall, redirects and latency
        do_reset();
        lat_min = 1; lat_max = 4; n_pop = 0;
        for (int k = 0; k < 1000; k++) begin
            rdy   = ($urandom_range(0, 1) == 1);
            stall = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 19) == 0);
            tgt   = $urandom & 32'hFFFF_FFFC;
            step();
        end
        redir = 0; stall = 0; rdy = 1;
        chk("t5_progress", n_pop > 100, 1);

        // 6: reset with three requests in flight
        do_reset();
        lat_min = 3; lat_max = 3; got = 0;
        for (int k = 0; k < 20; k++) begin
            if (!got) begin
                step();
                if (memq.size() == 3) got = 1;
            end
        end
        chk("t6_three_inflight", got, 1);
        rst_n = 0;
        step();
        #1;
        chk("t6_inflight", dut.inflight, 0);
        chk("t6_count", dut.count, 0);
        chk("t6_drop", dut.drop, 0);
        rst_n = 1;
        step();
        chk("t6_valid_after", s_valid, 0);
        chk("t6_first_fire", s_fire, 1);
        chk("t6_first_addr", s_addr, RPC);
        for (int k = 0; k < 10; k++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
